// File: rtl/divu_pkg.sv
// divu_pkg: constants and types shared by the HI/LO divider and the
// execute-stage result multiplexer.
//   WIDTH        operand/result width (only 32 is supported)
//   FUNCT_DIVU   funct code of DIVU
//   FUNCT_MFHI   funct code of MFHI
//   FUNCT_MFLO   funct code of MFLO
//   state_t      divider control states (IDLE, BUSY)
package divu_pkg;

    localparam int WIDTH = 32;

    localparam logic [5:0] FUNCT_DIVU = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO = 6'b010010;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // True for every instruction that touches HI/LO and therefore has to
    // wait for an in-flight division.
    function automatic logic is_hilo_op(input logic [5:0] funct);
        return (funct == FUNCT_DIVU) || (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO);
    endfunction

endpackage

// File: rtl/divu_step.sv
// divu_step: one combinational iteration of restoring unsigned division.
//   rem       in   WIDTH+1  partial remainder
//   q         in   WIDTH    quotient / remaining dividend shift register
//   divisor   in   WIDTH    divisor
//   rem_next  out  WIDTH+1  partial remainder after this iteration
//   q_next    out  WIDTH    shift register after this iteration (new LSB = quotient bit)
module divu_step
    import divu_pkg::*;
#(
    parameter int WIDTH = divu_pkg::WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The remainder is always below the divisor, so its top bit is never
    // needed to form the shifted value.
    logic unused_rem_msb;
    assign unused_rem_msb = rem[WIDTH];

    always_comb begin
        shifted = {rem[WIDTH-1:0], q[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next = trial;
            q_next   = {q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted;
            q_next   = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divu_hilo.sv
// divu_hilo: multi-cycle unsigned divider with the HI/LO register pair for
// the execute stage. A DIVU runs 32 restoring iterations, then writes the
// remainder to HI and the quotient to LO.
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous active-high reset
//   issue   in   1      execute-stage instruction valid
//   Signal  in   6      funct field of the execute-stage instruction
//   dataA   in   WIDTH  dividend (rs)
//   dataB   in   WIDTH  divisor (rt)
//   HiOut   out  WIDTH  HI register (remainder)
//   LoOut   out  WIDTH  LO register (quotient)
//   busy    out  1      a division is in progress
//   stall   out  1      freeze IF/ID/EX this cycle
//   done    out  1      one-cycle pulse after HI/LO are updated
//   dbz     out  1      last division had a zero divisor (DIVU_DBZ_FLAG_EN only)
// Optional feature macro: DIVU_DBZ_FLAG_EN adds the dbz output.
module divu_hilo
    import divu_pkg::*;
#(
    parameter int WIDTH = divu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             busy,
    output logic             stall,
    output logic             done
`ifdef DIVU_DBZ_FLAG_EN
    ,
    output logic             dbz
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  count_q;

    logic [WIDTH:0]    rem_q;
    logic [WIDTH-1:0]  q_q;
    logic [WIDTH-1:0]  divisor_q;

    logic [WIDTH:0]    rem_next;
    logic [WIDTH-1:0]  q_next;

    logic              start;
    logic              last;

    assign busy  = (state_q == BUSY);
    assign start = (state_q == IDLE) && issue && (Signal == FUNCT_DIVU);
    assign last  = busy && (count_q == CNT_W'(WIDTH - 1));

    // Only instructions that use HI/LO wait; everything else keeps flowing.
    assign stall = busy && issue && is_hilo_op(Signal);

    divu_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (rem_q),
        .q        (q_q),
        .divisor  (divisor_q),
        .rem_next (rem_next),
        .q_next   (q_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and architectural HI/LO state; reset aborts a division at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            HiOut   <= '0;
            LoOut   <= '0;
            done    <= 1'b0;
`ifdef DIVU_DBZ_FLAG_EN
            dbz     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done    <= last;
            if (start) begin
                count_q <= '0;
            end else if (busy) begin
                count_q <= count_q + 1'b1;
            end
            if (last) begin
                HiOut <= rem_next[WIDTH-1:0];
                LoOut <= q_next;
`ifdef DIVU_DBZ_FLAG_EN
                dbz   <= (divisor_q == '0);
`endif
            end
        end
    end

    // Iteration datapath: loaded on start, advanced once per busy cycle.
    always_ff @(posedge clk) begin
        if (start) begin
            rem_q     <= '0;
            q_q       <= dataA;
            divisor_q <= dataB;
        end else if (busy) begin
            rem_q <= rem_next;
            q_q   <= q_next;
        end
    end

endmodule

// File: tb/tb_divu_hilo.sv
module tb_divu_hilo;
    import divu_pkg::*;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue;
    logic [5:0]  Signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        busy;
    logic        stall;
    logic        done;
`ifdef DIVU_DBZ_FLAG_EN
    logic        dbz;
`endif

    divu_hilo #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .issue  (issue),
        .Signal (Signal),
        .dataA  (dataA),
        .dataB  (dataB),
        .HiOut  (HiOut),
        .LoOut  (LoOut),
        .busy   (busy),
        .stall  (stall),
        .done   (done)
`ifdef DIVU_DBZ_FLAG_EN
        ,
        .dbz    (dbz)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors    = 0;
    int   miscompares = 0;
    int   done_cnt   = 0;

    // Reference: plain integer division; a zero divisor yields an all-ones
    // quotient and leaves the dividend as remainder.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 32'd0) begin
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
        end else begin
            e.hi  = a % b;
            e.lo  = a / b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse retires the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            check1("busy_low_at_done", busy, 1'b0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 expected no pending division");
            end else begin
                mon_e = exp_q.pop_front();
                check32("hi", HiOut, mon_e.hi);
                check32("lo", LoOut, mon_e.lo);
`ifdef DIVU_DBZ_FLAG_EN
                check1("dbz", dbz, mon_e.dbz);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check1("wait_idle_bound", busy, 1'b0);
    endtask

    // Called at a negedge; returns at the negedge just after the start edge.
    task automatic issue_divu(input logic [31:0] a, input logic [31:0] b, input bit push);
        wait_idle();
        issue  = 1'b1;
        Signal = FUNCT_DIVU;
        dataA  = a;
        dataB  = b;
        if (push) exp_q.push_back(model(a, b));
        @(negedge clk);
        check1("start_accepted", busy, 1'b1);
        issue  = 1'b0;
        Signal = FUNCT_ADD;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        issue_divu(a, b, 1'b1);
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check32("busy_cycles", 32'(n), 32'd32);
    endtask

    initial begin
        int d0;
        int n;
        int stall_low;
        logic [31:0] a;
        logic [31:0] b;

        rst    = 1'b1;
        issue  = 1'b0;
        Signal = 6'd0;
        dataA  = 32'd0;
        dataB  = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check32("reset_hi", HiOut, 32'd0);
        check32("reset_lo", LoOut, 32'd0);
        check1("reset_busy", busy, 1'b0);
        check1("reset_stall", stall, 1'b0);
        check1("reset_done", done, 1'b0);
`ifdef DIVU_DBZ_FLAG_EN
        check1("reset_dbz", dbz, 1'b0);
`endif
        rst = 1'b0;

        // Directed divisions, including divide-by-zero and all-ones dividend.
        d0 = done_cnt;
        run_div(32'd100, 32'd7);
        @(negedge clk);
        check1("done_single_pulse", done, 1'b0);
        check32("done_count_100_7", 32'(done_cnt), 32'(d0 + 1));
        check32("hold_hi_100_7", HiOut, 32'd2);
        check32("hold_lo_100_7", LoOut, 32'd14);
        run_div(32'hFFFF_FFFF, 32'd1);
        run_div(32'd3, 32'd10);
        run_div(32'd5, 32'd0);
        run_div(32'd8, 32'd2);

        // Hazards during a division: unrelated ops flow, HI/LO users stall.
        issue_divu(32'd1000, 32'd33, 1'b1);
        @(negedge clk);
        issue  = 1'b1;
        Signal = FUNCT_ADD;
        #1 check1("add_no_stall", stall, 1'b0);
        @(negedge clk);
        Signal = FUNCT_MFLO;
        #1 check1("mflo_stall", stall, 1'b1);
        @(negedge clk);
        Signal = FUNCT_MFHI;
        n = 0;
        stall_low = 0;
        while (busy === 1'b1 && n < 100) begin
            #1 if (stall !== 1'b1) stall_low++;
            n++;
            @(negedge clk);
        end
        check32("mfhi_stall_low_cycles", 32'(stall_low), 32'd0);
        #1 check1("mfhi_released", stall, 1'b0);
        check32("mfhi_new_hi", HiOut, 32'd10);
        check32("mflo_new_lo", LoOut, 32'd30);
        issue  = 1'b0;
        Signal = FUNCT_ADD;
        @(negedge clk);

        // Asynchronous reset in the middle of a division.
        d0 = done_cnt;
        issue_divu(32'd77777, 32'd13, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check1("abort_busy", busy, 1'b0);
        check32("abort_hi", HiOut, 32'd0);
        check32("abort_lo", LoOut, 32'd0);
        check1("abort_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check32("abort_no_done", 32'(done_cnt), 32'(d0));

        // Back-to-back DIVUs with issue held: second starts right after done.
        wait_idle();
        issue  = 1'b1;
        Signal = FUNCT_DIVU;
        dataA  = 32'd20;
        dataB  = 32'd3;
        exp_q.push_back(model(32'd20, 32'd3));
        @(negedge clk);
        check1("b2b_first_start", busy, 1'b1);
        dataA = 32'd9;
        dataB = 32'd4;
        exp_q.push_back(model(32'd9, 32'd4));
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check1("b2b_first_done", done, 1'b1);
        @(negedge clk);
        check1("b2b_second_start", busy, 1'b1);
        issue  = 1'b0;
        Signal = FUNCT_ADD;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check32("b2b_hi", HiOut, 32'd1);
        check32("b2b_lo", LoOut, 32'd2);

        // Randomized divisions against the reference model.
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = $urandom;
                default: b = a >> $urandom_range(0, 31);
            endcase
            run_div(a, b);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check32("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
